// File: rtl/flag_register_if.sv
// flag_register_if: ALU status, branch request and flag/branch result signals
// exchanged between the datapath/branch logic (master) and the flag register
// (slave). Clock and reset stay plain ports on the modules.
interface flag_register_if;
  // ALU status outputs
  logic       negative;
  logic       zero;
  logic       carry_out;
  logic       overflow;
  logic       set_flags;

  // Branch requests
  logic       branch_req;
  logic [3:0] cond;
  logic       cbz_req;
  logic       cbz_zero;

  // Flag register results
  logic [3:0] flags_q;
  logic       flags_valid;
  logic       take_branch;
  logic       stall;

  modport master (
    output negative, zero, carry_out, overflow, set_flags,
    output branch_req, cond, cbz_req, cbz_zero,
    input  flags_q, flags_valid, take_branch, stall
  );

  modport slave (
    input  negative, zero, carry_out, overflow, set_flags,
    input  branch_req, cond, cbz_req, cbz_zero,
    output flags_q, flags_valid, take_branch, stall
  );
endinterface

// File: rtl/flag_register.sv
// flag_register: architectural NZCV flags, B.cond / CBZ decision logic.
//
// Build option FLAG_BYPASS_EN:
//   defined   - B.cond reads the incoming ALU flags when set_flags=1, so a
//               flag write and a dependent branch resolve in the same cycle;
//               stall is tied low and no interlock is built.
//   undefined - B.cond always reads flags_q; a branch arriving together with
//               a flag write is held for one cycle by a two-state interlock.
//
// Interlock states (bypass not built):
//   state | meaning
//   IDLE  | no pending collision; branches resolve against flags_q
//   WAIT  | stalled last cycle; flags_q now holds the new flags, resolve now
module flag_register (
  input  logic             clk,
  input  logic             reset,
  flag_register_if.slave   bus
);

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HS = 4'b0010;
  localparam logic [3:0] COND_LO = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;

  logic [3:0] flags_r;
  logic       valid_r;
  logic [3:0] alu_flags;
  logic       take_c;
  logic       stall_c;

  assign alu_flags = {bus.negative, bus.zero, bus.carry_out, bus.overflow};

  // Evaluate a B.cond condition field against a {N,Z,C,V} flag set.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_HS: r = cy;
      COND_LO: r = ~cy;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = cy & ~z;
      COND_LS: r = ~cy | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      default: r = 1'b1;  // AL and 1111
    endcase
    return r;
  endfunction

  // Flag register and first-write tracker; identical in both builds.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r <= 4'b0000;
      valid_r <= 1'b0;
    end else if (bus.set_flags) begin
      flags_r <= alu_flags;
      valid_r <= 1'b1;
    end
  end

  assign bus.flags_q     = flags_r;
  assign bus.flags_valid = valid_r;
  assign bus.take_branch = take_c;
  assign bus.stall       = stall_c;

`ifdef FLAG_BYPASS_EN

  logic [3:0] flag_src;

  // Branch decision with same-cycle forwarding of the flags being written.
  always_comb begin
    flag_src = bus.set_flags ? alu_flags : flags_r;
    take_c   = 1'b0;
    if (!reset) begin
      if (bus.cbz_req) begin
        take_c = bus.cbz_zero;
      end else if (bus.branch_req) begin
        take_c = cond_holds(bus.cond, flag_src);
      end
    end
  end

  assign stall_c = 1'b0;

`else

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Interlock state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and branch/stall decision. CBZ has priority over B.cond and
  // never stalls, so only a B.cond alone can collide with a flag write.
  always_comb begin
    state_d = IDLE;
    take_c  = 1'b0;
    stall_c = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (bus.branch_req && bus.set_flags && !bus.cbz_req) begin
            stall_c = 1'b1;
            state_d = WAIT;
          end else if (bus.cbz_req) begin
            take_c = bus.cbz_zero;
          end else if (bus.branch_req) begin
            take_c = cond_holds(bus.cond, flags_r);
          end
        end
        WAIT: begin
          // flags_q already holds the flags written on the stalling edge; a
          // further write this cycle lands on the edge after the decision.
          if (bus.cbz_req) begin
            take_c = bus.cbz_zero;
          end else if (bus.branch_req) begin
            take_c = cond_holds(bus.cond, flags_r);
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_flag_register.sv
module tb_flag_register;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  flag_register_if bus ();

  flag_register dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] m_flags;
  logic       m_valid;
  logic       m_pending;   // a B.cond was held back last cycle
  logic       exp_take;
  logic       exp_stall;

`ifdef FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ARM-style decode: cond[3:1] selects a base test, cond[0] inverts it
  // (except for the always-true 111x group).
  function automatic logic cond_true(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cy;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cy & ~z;
      3'd5:    r = (n == v);
      3'd6:    r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && (c[3:1] != 3'd7)) r = ~r;
    return r;
  endfunction

  task automatic drive(input logic rst, input logic [3:0] nzcv, input logic sf,
                       input logic br, input logic [3:0] cd,
                       input logic cb, input logic cbzz);
    reset          = rst;
    bus.negative   = nzcv[3];
    bus.zero       = nzcv[2];
    bus.carry_out  = nzcv[1];
    bus.overflow   = nzcv[0];
    bus.set_flags  = sf;
    bus.branch_req = br;
    bus.cond       = cd;
    bus.cbz_req    = cb;
    bus.cbz_zero   = cbzz;
  endtask

  // Compute expected combinational outputs and compare.
  task automatic check_comb(input string tag);
    logic [3:0] src;
    logic       collide;
    exp_take  = 1'b0;
    exp_stall = 1'b0;
    collide   = bus.branch_req && bus.set_flags && !bus.cbz_req;
    src       = (BYPASS && bus.set_flags) ? {bus.negative, bus.zero, bus.carry_out, bus.overflow} : m_flags;
    if (!reset) begin
      if (!BYPASS && !m_pending && collide) begin
        exp_stall = 1'b1;
      end else if (bus.cbz_req) begin
        exp_take = bus.cbz_zero;
      end else if (bus.branch_req) begin
        exp_take = cond_true(src, bus.cond);
      end
    end
    n_checks++;
    assert (bus.take_branch === exp_take) else begin
      n_fails++;
      $error("FAIL %s take_branch observed=%b expected=%b", tag, bus.take_branch, exp_take);
    end
    n_checks++;
    assert (bus.stall === exp_stall) else begin
      n_fails++;
      $error("FAIL %s stall observed=%b expected=%b", tag, bus.stall, exp_stall);
    end
  endtask

  // Clock edge: advance the model, then check registered outputs.
  task automatic tick(input string tag);
    logic [3:0] nf;
    logic       nv, np;
    nf = m_flags;
    nv = m_valid;
    np = 1'b0;
    if (reset) begin
      nf = 4'b0000;
      nv = 1'b0;
    end else begin
      if (bus.set_flags) begin
        nf = {bus.negative, bus.zero, bus.carry_out, bus.overflow};
        nv = 1'b1;
      end
      np = exp_stall;
    end
    @(posedge clk);
    m_flags   = nf;
    m_valid   = nv;
    m_pending = np;
    #1;
    n_checks++;
    assert (bus.flags_q === m_flags) else begin
      n_fails++;
      $error("FAIL %s flags_q observed=%b expected=%b", tag, bus.flags_q, m_flags);
    end
    n_checks++;
    assert (bus.flags_valid === m_valid) else begin
      n_fails++;
      $error("FAIL %s flags_valid observed=%b expected=%b", tag, bus.flags_valid, m_valid);
    end
  endtask

  task automatic step(input string tag);
    #2;
    check_comb(tag);
    tick(tag);
  endtask

  initial begin
    logic [15:0] sweep_mask;
    logic [3:0]  rnd_flags;
    n_checks  = 0;
    n_fails   = 0;
    m_flags   = 4'b0000;
    m_valid   = 1'b0;
    m_pending = 1'b0;
    exp_take  = 1'b0;
    exp_stall = 1'b0;
    // Truth of each cond for N=0 Z=1 C=1 V=0 (EQ HS PL VC LS GE LE AL 1111).
    sweep_mask = 16'hE6A5;

    drive(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    // Reset held: outputs quiet even with a request present
    step("reset0");
    step("reset1");

    // Load N0 Z1 C1 V0
    drive(1'b0, 4'b0110, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    step("load");
    n_checks++;
    assert (bus.flags_q === 4'b0110) else begin
      n_fails++;
      $error("FAIL load_direct flags_q observed=%b expected=%b", bus.flags_q, 4'b0110);
    end

    // Condition sweep against flags 0110
    for (int i = 0; i < 16; i++) begin
      logic [3:0] cd;
      cd = 4'(i);
      drive(1'b0, 4'b1001, 1'b0, 1'b1, cd, 1'b0, 1'b0);
      #2;
      check_comb($sformatf("sweep%0d", i));
      n_checks++;
      assert (bus.take_branch === sweep_mask[i]) else begin
        n_fails++;
        $error("FAIL sweep_table%0d take_branch observed=%b expected=%b", i, bus.take_branch, sweep_mask[i]);
      end
      tick($sformatf("sweep%0d", i));
    end

    // CBZ overrides B.cond NE with Z=1
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1);
    step("cbz_taken");
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
    step("cbz_not_taken");

    // Collision: flags cleared, then write Z=1 with dependent B.EQ
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    step("clear");
    drive(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    #2;
    check_comb("coll_c0");
    n_checks++;
    assert (bus.stall === !BYPASS && bus.take_branch === BYPASS) else begin
      n_fails++;
      $error("FAIL coll_c0_direct stall/take observed=%b%b expected=%b%b",
             bus.stall, bus.take_branch, !BYPASS, BYPASS);
    end
    tick("coll_c0");
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    #2;
    check_comb("coll_c1");
    n_checks++;
    assert (bus.stall === 1'b0 && bus.take_branch === 1'b1) else begin
      n_fails++;
      $error("FAIL coll_c1_direct stall/take observed=%b%b expected=01", bus.stall, bus.take_branch);
    end
    tick("coll_c1");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    step("coll_c2");

    // Back-to-back collisions alternate stall 1,0
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'(i), 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
      step($sformatf("b2b%0d", i));
    end

    // Reset asserted in the WAIT cycle
    drive(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    step("rst_coll");
    drive(1'b1, 4'b0100, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    step("rst_in_wait");
    n_checks++;
    assert (bus.flags_q === 4'b0000 && bus.flags_valid === 1'b0) else begin
      n_fails++;
      $error("FAIL rst_in_wait_direct flags_q/valid observed=%b/%b expected=0000/0",
             bus.flags_q, bus.flags_valid);
    end
    drive(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    step("post_rst_c0");
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    step("post_rst_c1");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rnd_flags = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 40) == 0), rnd_flags,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      step($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
